rv_test_monitor: RTL and testbench

//  Synthesizable completion monitor for riscv-tests programs on the rv_soc core.

---
 rtl/rv_test_monitor.sv | 127 ++++++++++++
 tb/tb_rv_test_monitor.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/rv_test_monitor.sv
// Completion monitor for riscv-tests: shadows the done/pass/testnum register writes and latches a sticky verdict.
// Optional watchdog timeout state when RV_TEST_MON_WATCHDOG_EN is defined.
module rv_test_monitor #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int DONE_REG    = 26,
  parameter int PASS_REG    = 27,
  parameter int NUM_REG     = 3,
  parameter int SETTLE_CYC  = 10,
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-1:0] fail_num
);

  typedef enum logic [2:0] {S_WAIT, S_SETTLE, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] DONE_IDX = ADDR_W'(DONE_REG);
  localparam logic [ADDR_W-1:0] PASS_IDX = ADDR_W'(PASS_REG);
  localparam logic [ADDR_W-1:0] NUM_IDX  = ADDR_W'(NUM_REG);

  state_t              st_q, st_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   pass_sh_q, pass_sh_d;
  logic [DATA_W-1:0]   num_sh_q, num_sh_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                fail_q, fail_d, timeout_q, timeout_d;
  logic [DATA_W-1:0]   fail_num_q, fail_num_d;
  logic                wr_ok, done_wr, live;

`ifndef RV_TEST_MON_WATCHDOG_EN
  logic unused_timeout_last;
  assign unused_timeout_last = ^TIMEOUT_LAST;
`endif

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    pass_sh_d = pass_sh_q;
    num_sh_d  = num_sh_q;
    wr_ok     = wr_en && (wr_addr != '0);
    done_wr   = wr_ok && (wr_addr == DONE_IDX) && (wr_data == DATA_W'(1));
    live      = (st_q == S_WAIT) || (st_q == S_SETTLE);

    case (st_q)
      S_WAIT: begin
        if (done_wr) begin
          st_d  = S_SETTLE;
          cnt_d = '0;
        end
`ifdef RV_TEST_MON_WATCHDOG_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          st_d = S_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_SETTLE: begin
        // Verdict reads the pre-edge shadow, so a same-edge PASS write is ignored.
        if (cnt_q == SETTLE_LAST) begin
          st_d = (pass_sh_q == DATA_W'(1)) ? S_PASS : S_FAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (live && wr_ok && (wr_addr == PASS_IDX)) pass_sh_d = wr_data;
    if (live && wr_ok && (wr_addr == NUM_IDX))  num_sh_d  = wr_data;

    busy_d     = (st_d == S_WAIT) || (st_d == S_SETTLE);
    done_d     = (st_d == S_PASS) || (st_d == S_FAIL) || (st_d == S_TIMEOUT);
    pass_d     = (st_d == S_PASS);
    fail_d     = (st_d == S_FAIL) || (st_d == S_TIMEOUT);
    timeout_d  = (st_d == S_TIMEOUT);
    fail_num_d = fail_d ? num_sh_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      st_q       <= S_WAIT;
      cnt_q      <= '0;
      pass_sh_q  <= '0;
      num_sh_q   <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fail_num_q <= '0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      pass_sh_q  <= pass_sh_d;
      num_sh_q   <= num_sh_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      fail_num_q <= fail_num_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = timeout_q;
  assign fail_num = fail_num_q;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Directed bench for rv_test_monitor (TIMEOUT_CYC=50; watchdog checks follow RV_TEST_MON_WATCHDOG_EN).
module tb_rv_test_monitor;

  logic        clk = 1'b0;
  logic        rst, wr_en, clr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, pass, fail, timeout;
  logic [31:0] fail_num;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  rv_test_monitor #(.TIMEOUT_CYC(50)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .fail_num(fail_num)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    idle(1);
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic b, input logic dn, input logic p,
                         input logic f, input logic [31:0] fn);
    chk({tag, ".busy"}, {31'b0, busy}, {31'b0, b});
    chk({tag, ".done"}, {31'b0, done}, {31'b0, dn});
    chk({tag, ".pass"}, {31'b0, pass}, {31'b0, p});
    chk({tag, ".fail"}, {31'b0, fail}, {31'b0, f});
    chk({tag, ".fail_num"}, fail_num, fn);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    idle(2);
    rst = 1'b0;
    chk_out("reset", 1, 0, 0, 0, 0);
    chk("reset.timeout", {31'b0, timeout}, 32'd0);

    // 1: pass, full latency
    wr(5'd3, 32'd5); wr(5'd27, 32'd1); wr(5'd26, 32'd1);
    idle(9);
    chk_out("pass.pre", 1, 0, 0, 0, 0);
    idle(1);
    chk_out("pass.verdict", 0, 1, 1, 0, 0);

    // 2: fail, sticky
    do_clr();
    chk_out("clr", 1, 0, 0, 0, 0);
    wr(5'd3, 32'd7); wr(5'd27, 32'd0); wr(5'd26, 32'd1);
    idle(9);
    chk_out("fail.pre", 1, 0, 0, 0, 0);
    idle(1);
    chk_out("fail.verdict", 0, 1, 0, 1, 32'd7);
    wr(5'd27, 32'd1); wr(5'd3, 32'd8); wr(5'd26, 32'd1);
    idle(97);
    chk_out("fail.sticky", 0, 1, 0, 1, 32'd7);

    // 3: spurious done then late pass write on the verdict edge
    do_clr();
    wr(5'd26, 32'd2);
    idle(12);
    chk_out("spurious", 1, 0, 0, 0, 0);
    wr(5'd3, 32'd9); wr(5'd27, 32'd0); wr(5'd26, 32'd1);
    wr(5'd26, 32'd1);
    idle(8);
    chk_out("late.pre", 1, 0, 0, 0, 0);
    wr(5'd27, 32'd1);
    chk_out("late.verdict", 0, 1, 0, 1, 32'd9);

    // 4: abort mid-settle clears shadows
    do_clr();
    wr(5'd3, 32'd3); wr(5'd27, 32'd1); wr(5'd26, 32'd1);
    idle(4);
    do_clr();
    chk_out("abort", 1, 0, 0, 0, 0);
    wr(5'd26, 32'd1);
    idle(10);
    chk_out("abort.shadow0", 0, 1, 0, 1, 32'd0);
    do_clr();
    wr(5'd3, 32'd4); wr(5'd27, 32'd1); wr(5'd26, 32'd1);
    idle(9);
    chk_out("fresh.pre", 1, 0, 0, 0, 0);
    idle(1);
    chk_out("fresh.verdict", 0, 1, 1, 0, 0);
    rst = 1'b1; clr = 1'b1;
    idle(1);
    rst = 1'b0; clr = 1'b0;
    chk_out("rst_clr", 1, 0, 0, 0, 0);

    // 6: x0 writes ignored
    wr(5'd0, 32'd1); wr(5'd0, 32'd1);
    idle(3);
    chk_out("x0.idle", 1, 0, 0, 0, 0);
    wr(5'd3, 32'd6); wr(5'd27, 32'd1); wr(5'd0, 32'd0); wr(5'd26, 32'd1);
    wr(5'd0, 32'd5);
    idle(9);
    chk_out("x0.verdict", 0, 1, 1, 0, 0);

    // 5: watchdog
    do_clr();
`ifdef RV_TEST_MON_WATCHDOG_EN
    idle(49);
    chk_out("wd.pre", 1, 0, 0, 0, 0);
    chk("wd.pre.timeout", {31'b0, timeout}, 32'd0);
    idle(1);
    chk_out("wd.expire", 0, 1, 0, 1, 32'd0);
    chk("wd.expire.timeout", {31'b0, timeout}, 32'd1);
`else
    idle(1000);
    chk_out("nowd.busy", 1, 0, 0, 0, 0);
    chk("nowd.timeout", {31'b0, timeout}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
